// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall FSM, memory-busy freeze,
// taken-branch flush and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset          : core clock, synchronous active-high reset
//   id_ex_mem_read/_rt  : load in EX and its destination register
//   if_id_rs/_rt        : ID source registers
//   if_id_uses_rt       : ID instruction reads rt
//   ex_branch_taken     : taken branch/jump resolved in EX
//   mem_req/mem_ready   : data memory access in flight / completing
//   stall_cnt_clr       : clears stall_cycles
//   pc_write            : PC advances
//   if_id_write         : IF/ID advances
//   id_ex_bubble        : zero controls into ID/EX
//   if_id_flush         : IF/ID loads a NOP
//   pipe_freeze         : ID/EX, EX/MEM, MEM/WB hold
//   stall_cycles        : saturating count of cycles with pc_write==0
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  id_ex_rt,
  input  logic [REG_ADDR_W-1:0]  if_id_rs,
  input  logic [REG_ADDR_W-1:0]  if_id_rt,
  input  logic                   if_id_uses_rt,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   stall_cnt_clr,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   pipe_freeze,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN,
    LSTALL
  } state_e;

  // Bubbles still owed after the first one, which is issued from RUN.
  localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_STALLS - 1);
  localparam bit         MULTI    = (LOAD_USE_STALLS > 1);

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic hazard;
  logic mem_wait;

  assign hazard = id_ex_mem_read
               && (id_ex_rt != '0)
               && ((id_ex_rt == if_id_rs)
                || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (mem_wait) begin
      // Whole pipe holds; any pending stall resumes afterwards.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      // Dependent ID instruction is wrong-path: drop the stall.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (state_q == LSTALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (cnt_q <= 3'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (MULTI) begin
        state_d = LSTALL;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_cnt_clr) begin
      stall_cycles_d = '0;
    end else if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
